// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard controller:
// FSM states, next-PC select codes, forwarding select codes.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } hz_state_e;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding selects and ID-stage write-through bypass.
// Purely combinational; r0 is never forwarded or bypassed.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             v_mem,
    input  logic             mem_regwr,
    input  logic             mem_ovf,
    input  logic [REG_W-1:0] mem_rw,
    input  logic             v_wb,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_rw,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b
);

    logic mem_live;
    logic wb_live;

    assign mem_live = v_mem & mem_regwr & ~mem_ovf;
    assign wb_live  = v_wb & wb_we;

    // MEM result is younger than WB data, so it wins when both match
    function automatic logic [1:0] pick_src(input logic [REG_W-1:0] src,
                                            input logic             m_live,
                                            input logic [REG_W-1:0] m_rw,
                                            input logic             w_live,
                                            input logic [REG_W-1:0] w_rw);
        logic [1:0] sel;
        if (src == REG_W'(REG_ZERO)) begin
            sel = FWD_RF;
        end else if (m_live && (m_rw == src)) begin
            sel = FWD_MEM;
        end else if (w_live && (w_rw == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    assign fwd_a    = pick_src(ex_rs, mem_live, mem_rw, wb_live, wb_rw);
    assign fwd_b    = pick_src(ex_rt, mem_live, mem_rw, wb_live, wb_rw);
    assign id_byp_a = wb_live & (wb_rw == id_rs) & (id_rs != REG_W'(REG_ZERO));
    assign id_byp_b = wb_live & (wb_rw == id_rt) & (id_rt != REG_W'(REG_ZERO));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: enables, flushes,
// forwarding, next-PC select, stage valid tracking, stall/redirect/halt FSM.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rw,
    input  logic             ex_regwr,
    input  logic             ex_memtoreg,
    input  logic [REG_W-1:0] mem_rw,
    input  logic             mem_regwr,
    input  logic             mem_ovf,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_jump,
    input  logic [REG_W-1:0] wb_rw,
    input  logic             wb_we,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       pc_sel,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic             v_id,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_e state;
    hz_state_e next_state;
    logic      load_use;
    logic      redirect;
    logic      stall_inc;
    logic      flush_inc;

    fwd_unit #(.REG_W(REG_W)) u_fwd (
        .v_mem     (v_mem),
        .mem_regwr (mem_regwr),
        .mem_ovf   (mem_ovf),
        .mem_rw    (mem_rw),
        .v_wb      (v_wb),
        .wb_we     (wb_we),
        .wb_rw     (wb_rw),
        .ex_rs     (ex_rs),
        .ex_rt     (ex_rt),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .id_byp_a  (id_byp_a),
        .id_byp_b  (id_byp_b)
    );

    // A load that never reaches the register file cannot create a hazard
    assign load_use = v_ex & ex_memtoreg & ex_regwr & (ex_rw != REG_W'(REG_ZERO)) &
                      ((id_use_rs & (id_rs == ex_rw)) | (id_use_rt & (id_rt == ex_rw)));
    assign redirect = v_mem & ((mem_branch & mem_zero) | mem_jump);
    assign halt_ack = (state == ST_HALTED);

    // Control outputs and next state; redirect > halt > load-use
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel      = PCSEL_SEQ;
        next_state  = state;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            next_state  = ST_RUN;
        end else begin
            case (state)
                ST_RUN, ST_LSTALL, ST_DRAIN: begin
                    if (redirect) begin
                        pc_sel      = mem_jump ? PCSEL_JMP : PCSEL_BR;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc   = 1'b1;
                        next_state  = halt_req ? ST_DRAIN : ST_RUN;
                    end else if (state == ST_DRAIN) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                        next_state = (v_ex | v_mem | v_wb) ? ST_DRAIN : ST_HALTED;
                    end else if (halt_req) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                        next_state = ST_DRAIN;
                    end else if ((state == ST_RUN) && load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                        next_state = ST_LSTALL;
                    end else begin
                        next_state = ST_RUN;
                    end
                end
                ST_HALTED: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    next_state = halt_req ? ST_HALTED : ST_RUN;
                end
                default: begin
                    next_state = ST_RUN;
                end
            endcase
        end
    end

    // FSM state, stage valid bits and saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            v_id      <= 1'b0;
            v_ex      <= 1'b0;
            v_mem     <= 1'b0;
            v_wb      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= next_state;
            v_id  <= ifid_flush ? 1'b0 : (ifid_en ? pc_en : v_id);
            v_ex  <= idex_flush ? 1'b0 : (idex_en ? v_id : v_ex);
            v_mem <= v_ex & ~exmem_flush;
            v_wb  <= v_mem;
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule
